// File: rtl/onehot_decoder_5to32.sv
// onehot_decoder_5to32: registered 5-to-32 one-hot decoder, valid/ready with 2-entry skid buffer.
// Define DEC_PARITY_EN to add in_par/out_err parity checking.
module onehot_decoder_5to32 #(
  parameter int CODE_OFFSET = 1
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef DEC_PARITY_EN
  input  logic        in_par,
  output logic        out_err,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_code,
  input  logic        in_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_onehot,
  output logic [4:0]  out_code
);
`ifdef DEC_PARITY_EN
  localparam int W = 38;
`else
  localparam int W = 37;
`endif
  localparam logic [4:0] OFS = 5'(CODE_OFFSET);
  // encoding is {M.valid, S.valid}
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b10, FULL = 2'b11} state_t;
  state_t state, nxt;
  logic [W-1:0] din, m_q, s_q;
  logic [4:0] idx;
  logic acc, xfer;
  assign idx = in_code - OFS;
  assign acc = in_valid & in_ready;
  assign xfer = state[1] & out_ready;
`ifdef DEC_PARITY_EN
  logic err;
  assign err = ^{in_code, in_par};
  assign din = {err, in_code, (in_en & ~err) ? 32'd1 << idx : 32'd0};
  assign out_err = state[1] & m_q[37];
`else
  assign din = {in_code, in_en ? 32'd1 << idx : 32'd0};
`endif
  assign out_valid = state[1];
  assign out_onehot = state[1] ? m_q[31:0] : 32'd0;
  assign out_code = m_q[36:32];
  always_comb begin
    nxt = state == FULL ? (xfer ? ONE : FULL) :
          state == ONE  ? (acc == xfer ? ONE : acc ? FULL : EMPTY) :
                          (acc ? ONE : EMPTY);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      in_ready <= 1'b0;
      m_q <= '0;
      s_q <= '0;
    end else begin
      state <= nxt;
      in_ready <= nxt != FULL;
      if (state == FULL && xfer) m_q <= s_q;
      else if (acc && (state == EMPTY || xfer)) m_q <= din;
      if (acc && state == ONE && !xfer) s_q <= din;
    end
  end
endmodule

// File: doc/onehot_decoder_5to32.md
# onehot_decoder_5to32

Registered 5-to-32 one-hot decoder with valid/ready handshake on both sides and a 2-entry skid buffer, so `in_ready` is a pure register output. It converts 5-bit register-select codes from the CPU datapath back into 32-bit one-hot strobes, such as register-file write enables. It is the inverse of the datapath's 32-to-5 one-hot encoder: bit *i* maps to code (*i*+1) mod 32.

## Interface
- `CODE_OFFSET`, default 1: code *c* selects output bit (*c* − `CODE_OFFSET`) mod 32. The default matches the encoder numbering, so code 0 selects bit 31 and code 1 selects bit 0.
- `clk` input, 1 bit: the single clock; all logic is rising-edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `in_valid` input, 1 bit: upstream code valid.
- `in_ready` output, 1 bit: block can accept; registered.
- `in_code` input, 5 bits: code to decode.
- `in_en` input, 1 bit: 1 decodes normally; 0 emits an all-zero strobe (a bubble that still handshakes).
- `out_valid` output, 1 bit: `out_onehot` and `out_code` are valid.
- `out_ready` input, 1 bit: downstream accepts.
- `out_onehot` output, 32 bits: decoded strobe, exactly one bit set, or zero when disabled or on error.
- `out_code` output, 5 bits: the accepted `in_code`, passed through.
- `in_par` input, 1 bit, only with `DEC_PARITY_EN`: even-parity bit over `in_code`.
- `out_err` output, 1 bit, only with `DEC_PARITY_EN`: parity error flag for the current output.

## Operation
- Storage is a main register (M) and a skid register (S). Each holds {onehot, code, err} plus a valid bit.
- Decode happens at input capture: onehot = `in_en` ? (1 << ((`in_code` − `CODE_OFFSET`) & 31)) : 0. Arithmetic is modulo 32 on 5 bits.
- Input accept = `in_valid` & `in_ready`. Output transfer = `out_valid` & `out_ready`.
- `out_*` always present M, and `out_valid` = M.valid.
- The state machine has three states, encoded by {M.valid, S.valid}:
  - EMPTY (0,0): on accept, load M and go to ONE.
  - ONE (1,0):
    - accept with transfer: reload M and stay in ONE.
    - accept without transfer: load S and go to FULL.
    - transfer without accept: go to EMPTY.
  - FULL (1,1): `in_ready` = 0.
    - transfer: M ← S and go to ONE.
    - no transfer: hold everything.
- `in_ready` is registered and equals 1 whenever the next state is not FULL.
- On a simultaneous accept and transfer in ONE, the new entry goes directly to M; no skid is used.
- Ordering is strict FIFO. Entries are never dropped or duplicated.
- Holding `in_valid` high while `in_ready` = 0 has no effect. Input data is sampled only on accept.
- When `out_valid` = 0, `out_onehot` reads 0 (zeroed, not held stale).
- Reset takes priority over any handshake in that cycle; entries in flight are discarded.

## Timing
- Latency is 1 cycle: an entry accepted at edge *n* appears on `out_*` after edge *n*, if M was free.
- Throughput is 1 entry per cycle when `out_ready` is held high.
- `in_ready` deasserts the cycle after entering FULL. It reasserts the cycle after the transfer out of FULL.
- Reset values while `rst_n` = 0 at an edge:
  - `out_valid` = 0
  - `out_onehot` = 0
  - `out_code` = 0
  - `out_err` = 0
  - `in_ready` = 0
- The first edge with `rst_n` = 1 sets `in_ready` = 1, so the earliest accept is the following edge.

## Configuration
- `DEC_PARITY_EN`, when defined:
  - adds `in_par` and `out_err`.
  - err = ^{`in_code`, `in_par`} is computed at capture and carried through M and S.
  - an entry with err = 1 has onehot forced to 0 and still handshakes normally.
- When undefined, the ports and err storage are absent and decode is unconditional.

## Test plan
- Reset then sweep: `out_ready` = 1 and codes 0..31 streamed back-to-back -> `out_onehot` = bit 31, then bit 0, 1, …, 30 on consecutive cycles. `out_code` echoes each code and no gaps occur.
- Backpressure:
  - `out_ready` = 0 while sending codes 5, 6, 7 -> `in_ready` falls after code 6 is accepted and code 7 waits.
  - raising `out_ready` -> outputs bits 4, 5, 6 in order, with no loss.
- Disable: `in_en` = 0 with code 9 -> `out_valid` = 1 and `out_onehot` = 0, `out_code` = 9.
- Reset mid-operation: FULL state, then `rst_n` = 0 for one edge -> all outputs 0 and `in_ready` = 0. One cycle later `in_ready` = 1 and no stale entry is emitted.
- `CODE_OFFSET` = 0: code 0 -> bit 0, code 31 -> bit 31.
- With `DEC_PARITY_EN`: code 3 with `in_par` = 1 -> `out_err` = 1 and `out_onehot` = 0. Code 3 with `in_par` = 0 -> `out_err` = 0 and `out_onehot` = bit 2.
